// File: rtl/io_pkg.sv
// Processor-wide IN/OUT constants and the responder FSM state type.
// Shared by the control unit decode and the I/O handshake port.
package io_pkg;

  localparam logic [5:0] OPC_IN  = 6'b010110;
  localparam logic [5:0] OPC_OUT = 6'b010111;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_ACK          = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } io_state_e;

endpackage

// File: rtl/io_handshake_port_if.sv
// CPU-side IN/OUT handshake bundle: request and OUT strobe from the control unit, ack and data back.
// The master drives in_req/fout/out_data; the slave answers with flagIN/in_data.
interface io_handshake_port_if #(
  parameter int DATA_W = 32
) ();

  logic              in_req;
  logic              fout;
  logic [DATA_W-1:0] out_data;
  logic              flagIN;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_req, fout, out_data,
    input  flagIN, in_data
  );

  modport slave (
    input  in_req, fout, out_data,
    output flagIN, in_data
  );

endinterface

// File: rtl/button_debounce.sv
// Button conditioner: 2-flop synchronizer plus a consecutive-mismatch counter; level moves after DB_CYCLES mismatches.
// Latency raw->level is 2 + DB_CYCLES cycles; rise_pulse follows level by zero cycles and lasts one cycle.
module button_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      // The counter clears on the flip itself, so it is bounded below DB_CYCLES and never wraps.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise_pulse = level & ~level_d;

endmodule

// File: rtl/io_handshake_port.sv
// IN/OUT responder: debounced enter press answers a pending IN with a one-cycle flagIN and latched switches.
// flagIN one cycle after the debounced press; OUT captures every fout cycle and never stalls.
module io_handshake_port
  import io_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SW_W      = 16,
  parameter int SIGN_EXT  = 0,
  parameter int DB_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  io_handshake_port_if.slave cpu,
  input  logic [SW_W-1:0]    sw_data,
  input  logic               btn_enter,
  output logic [DATA_W-1:0]  out_reg,
  output logic [7:0]         out_count,
  output logic               waiting
);

  io_state_e         state;
  io_state_e         state_nxt;
  logic              level;
  logic              press_evt;
  logic              ack;
  logic [DATA_W-1:0] sw_ext;
  logic [DATA_W-1:0] in_data_q;

  button_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw       (btn_enter),
    .level     (level),
    .rise_pulse(press_evt)
  );

  generate
    if (SW_W == DATA_W) begin : g_pass
      assign sw_ext = sw_data;
    end else begin : g_ext
      logic fill;
      assign fill   = (SIGN_EXT != 0) && sw_data[SW_W-1];
      assign sw_ext = {{(DATA_W - SW_W){fill}}, sw_data};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Release only needs the debounced level low; IDLE re-examines in_req, so a held IN needs a fresh press.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:         if (cpu.in_req) state_nxt = ST_WAIT_PRESS;
      ST_WAIT_PRESS:   if (!cpu.in_req) state_nxt = ST_IDLE;
                       else if (press_evt) state_nxt = ST_ACK;
      ST_ACK:          state_nxt = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: if (!level) state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack     = 1'b0;
    waiting = 1'b0;
    case (state)
      ST_ACK:        ack     = !reset;
      ST_WAIT_PRESS: waiting = 1'b1;
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_data_q <= '0;
    end else if (state == ST_WAIT_PRESS && cpu.in_req && press_evt) begin
      in_data_q <= sw_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg   <= '0;
      out_count <= '0;
    end else if (cpu.fout) begin
      out_reg   <= cpu.out_data;
      out_count <= out_count + 8'd1;
    end
  end

  assign cpu.flagIN  = ack;
  assign cpu.in_data = in_data_q;

endmodule

// File: tb/tb_io_handshake_port.sv
// Bench for io_handshake_port: zero- and sign-extending instances share stimulus and a behavioural model.
module tb_io_handshake_port;
  import io_pkg::*;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        fout = 1'b0;
  logic [31:0] out_data = 32'd0;
  logic [15:0] sw_data = 16'd0;
  logic        btn_enter = 1'b0;
  logic [31:0] out_reg0, out_reg1;
  logic [7:0]  out_count0, out_count1;
  logic        w0, w1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  io_handshake_port_if #(.DATA_W(32)) if0 ();
  io_handshake_port_if #(.DATA_W(32)) if1 ();

  assign if0.in_req   = (opcode == OPC_IN);
  assign if1.in_req   = (opcode == OPC_IN);
  assign if0.fout     = fout;
  assign if1.fout     = fout;
  assign if0.out_data = out_data;
  assign if1.out_data = out_data;

  io_handshake_port #(.DATA_W(32), .SW_W(16), .SIGN_EXT(0), .DB_CYCLES(DB)) dut0 (
    .clk(clk), .reset(reset), .cpu(if0), .sw_data(sw_data), .btn_enter(btn_enter),
    .out_reg(out_reg0), .out_count(out_count0), .waiting(w0));

  io_handshake_port #(.DATA_W(32), .SW_W(16), .SIGN_EXT(1), .DB_CYCLES(DB)) dut1 (
    .clk(clk), .reset(reset), .cpu(if1), .sw_data(sw_data), .btn_enter(btn_enter),
    .out_reg(out_reg1), .out_count(out_count1), .waiting(w1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: the button is judged on its recent sampled history, the handshake as
  // "waiting for a press", "acknowledging" and "holding until release" phases.
  bit          m_lvl = 0, m_lvl_d = 0, m_wait = 0, m_ack = 0, m_rel = 0;
  bit          r1 = 0, r2 = 0;
  bit          syn_q[$];
  logic [31:0] m_in0 = 0, m_in1 = 0, m_out = 0;
  logic [7:0]  m_cnt = 0;

  always @(posedge clk) begin
    bit rise, flip;
    rise = m_lvl && !m_lvl_d;
    if (reset) begin
      m_lvl = 0; m_lvl_d = 0; m_wait = 0; m_ack = 0; m_rel = 0;
      r1 = 0; r2 = 0; syn_q.delete();
      m_in0 = 0; m_in1 = 0; m_out = 0; m_cnt = 0;
    end else begin
      if (m_ack) begin
        m_ack = 0; m_rel = 1;
      end else if (m_rel) begin
        if (!m_lvl) m_rel = 0;
      end else if (m_wait) begin
        if (opcode != OPC_IN) m_wait = 0;
        else if (rise) begin
          m_wait = 0; m_ack = 1;
          m_in0 = {16'h0000, sw_data};
          m_in1 = {{16{sw_data[15]}}, sw_data};
        end
      end else if (opcode == OPC_IN) begin
        m_wait = 1;
      end
      if (fout) begin
        m_out = out_data;
        m_cnt = m_cnt + 8'd1;
      end
      m_lvl_d = m_lvl;
      syn_q.push_back(r2);
      if (syn_q.size() > DB) void'(syn_q.pop_front());
      flip = (syn_q.size() == DB);
      foreach (syn_q[i]) if (syn_q[i] == m_lvl) flip = 0;
      if (flip) m_lvl = !m_lvl;
      r2 = r1;
      r1 = btn_enter;
    end
  end

  bit prev_f = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("flagIN0", 32'(if0.flagIN), 32'(m_ack && !reset));
      chk("flagIN1", 32'(if1.flagIN), 32'(m_ack && !reset));
      chk("in_data0", if0.in_data, m_in0);
      chk("in_data1", if1.in_data, m_in1);
      chk("waiting0", 32'(w0), 32'(m_wait));
      chk("waiting1", 32'(w1), 32'(m_wait));
      chk("out_reg0", out_reg0, m_out);
      chk("out_reg1", out_reg1, m_out);
      chk("out_count0", 32'(out_count0), 32'(m_cnt));
      chk("out_count1", 32'(out_count1), 32'(m_cnt));
      chk("flagIN_consec", 32'(if0.flagIN && prev_f), 32'd0);
      prev_f = if0.flagIN;
    end
  end

  task automatic do_in(input logic [15:0] sw, output int lat, output logic [31:0] d0,
                       output logic [31:0] d1);
    lat = -1; d0 = 32'hx; d1 = 32'hx;
    sw_data = sw;
    opcode  = OPC_IN;
    for (int k = 0; k < 20 && !w0; k++) step();
    chk("reach_wait", 32'(w0), 32'd1);
    btn_enter = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      #1;
      if (if0.flagIN) begin
        lat = k; d0 = if0.in_data; d1 = if1.in_data;
        break;
      end
    end
    step();
    opcode    = 6'd0;
    btn_enter = 1'b0;
    repeat (15) step();
  endtask

  int          lat, nflag, btn_run, req_run;
  logic [31:0] d0, d1;

  initial begin
    // 1: reset, then a press with no IN pending is ignored
    step();
    chk_en = 1;
    step();
    reset = 1'b0;
    #1;
    chk("rst_flagIN", 32'(if0.flagIN), 32'd0);
    chk("rst_in_data", if0.in_data, 32'd0);
    chk("rst_out_reg", out_reg0, 32'd0);
    chk("rst_out_count", 32'(out_count0), 32'd0);
    chk("rst_waiting", 32'(w0), 32'd0);
    nflag = 0;
    btn_enter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) btn_enter = 1'b0;
      step(); #1;
      if (if0.flagIN) nflag++;
    end
    chk("idle_press_flags", nflag, 0);
    chk("idle_press_in_data", if0.in_data, 32'd0);

    // 5: OUT capture and count wrap
    fout = 1'b1;
    out_data = 32'd5; step();
    out_data = 32'd6; step();
    out_data = 32'd7; step();
    fout = 1'b0; step(); #1;
    chk("out_reg_7", out_reg0, 32'd7);
    chk("out_count_3", 32'(out_count0), 32'd3);
    for (int i = 0; i < 256; i++) begin
      fout = 1'b1; out_data = i; step();
      fout = 1'b0; step();
    end
    #1;
    chk("out_count_wrap", 32'(out_count0), 32'd3);
    chk("out_reg_last", out_reg0, 32'd255);

    // 2: basic IN, latency from raw press
    do_in(16'h00A5, lat, d0, d1);
    chk("in_latency", lat, 7);
    chk("in_data_A5", d0, 32'h000000A5);

    // 3: zero vs sign extension
    do_in(16'h8001, lat, d0, d1);
    chk("zext_8001", d0, 32'h00008001);
    chk("sext_8001", d1, 32'hFFFF8001);

    // 4: bounce then hold through back-to-back INs
    opcode = OPC_IN;
    sw_data = 16'h1234;
    nflag = 0;
    for (int i = 0; i < 20; i++) begin
      btn_enter = ((i / 2) % 2 == 0);
      step(); #1;
      if (if0.flagIN) nflag++;
    end
    btn_enter = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(); #1;
      if (if0.flagIN) nflag++;
    end
    chk("hold_one_flag", nflag, 1);
    btn_enter = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(); #1;
      if (if0.flagIN) nflag++;
    end
    chk("release_no_flag", nflag, 1);
    chk("rearmed_waiting", 32'(w0), 32'd1);
    btn_enter = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(); #1;
      if (if0.flagIN) nflag++;
    end
    chk("second_press_flag", nflag, 2);
    opcode = 6'd0;
    btn_enter = 1'b0;
    repeat (15) step();

    // 6: reset in the cycle before ACK
    opcode = OPC_IN;
    for (int k = 0; k < 20 && !w0; k++) step();
    btn_enter = 1'b1;
    for (int k = 0; k < 30 && !(m_lvl && !m_lvl_d); k++) step();
    chk("press_seen", 32'(m_lvl && !m_lvl_d && w0), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_cycle_flag", 32'(if0.flagIN), 32'd0);
    step();
    reset = 1'b0; opcode = 6'd0; btn_enter = 1'b0;
    #1;
    chk("post_rst_flag", 32'(if0.flagIN), 32'd0);
    chk("post_rst_waiting", 32'(w0), 32'd0);
    chk("post_rst_in_data", if0.in_data, 32'd0);
    repeat (15) step();

    // random traffic against the model
    btn_run = 0; req_run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (btn_run == 0) begin
        btn_enter = 1'($urandom_range(0, 1));
        btn_run = $urandom_range(1, 12);
      end
      btn_run--;
      if (req_run == 0) begin
        opcode = ($urandom_range(0, 2) != 0) ? OPC_IN : OPC_OUT;
        req_run = $urandom_range(1, 20);
      end
      req_run--;
      fout = ($urandom_range(0, 2) == 0);
      out_data = $urandom;
      if ($urandom_range(0, 15) == 0) sw_data = 16'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
